mux2_packet_arbiter: RTL and testbench

Two-input, packet-atomic round-robin arbiter that shares the 2:1 datapath mux between two upstream NoC channels and drives one registered downstream channel. It generates the mux select, holds the grant for the whole packet (up to and including the `last` beat), and provides a one-beat output register with a valid/ready handshake. It sits at switch output ports wherever two flit streams merge onto one link.

---
 rtl/common_pkg.sv | 8 +
 rtl/mux2_packet_arbiter_if.sv | 28 ++
 rtl/mux.sv | 13 +
 rtl/mux2_packet_arbiter.sv | 92 +++++++++
 tb/tb_mux2_packet_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/common_pkg.sv
// Shared types and widths for the switch datapath blocks.
package common_pkg;

  localparam int DEFAULT_D_W = 16;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

endpackage

// File: rtl/mux2_packet_arbiter_if.sv
// Two upstream flit channels merging onto one registered downstream channel.
interface mux2_packet_arbiter_if
  import common_pkg::*;
#(
  parameter int W = DEFAULT_D_W
);

  logic [1:0]        i_valid;
  logic [1:0][W-1:0] i_data;
  logic [1:0]        i_last;
  logic [1:0]        i_ready;
  logic              o_valid;
  logic [W-1:0]      o_data;
  logic              o_last;
  logic              o_src;
  logic              o_ready;

  modport slave (
    input  i_valid, i_data, i_last, o_ready,
    output i_ready, o_valid, o_data, o_last, o_src
  );

  modport master (
    output i_valid, i_data, i_last, o_ready,
    input  i_ready, o_valid, o_data, o_last, o_src
  );

endinterface

// File: rtl/mux.sv
// Generic N:1 word multiplexer driven by a binary select.
module mux #(
  parameter int N = 2,
  parameter int W = 8
) (
  input  logic [N-1:0][W-1:0]     din,
  input  logic [$clog2(N)-1:0]    sel,
  output logic [W-1:0]            dout
);

  assign dout = din[sel];

endmodule

// File: rtl/mux2_packet_arbiter.sv
// Packet-atomic round-robin arbiter for two flit streams with a one-beat output register.
// A grant is held from the first flit of a packet until its last flit is loaded.
module mux2_packet_arbiter
  import common_pkg::*;
#(
  parameter int W = DEFAULT_D_W
) (
  input logic                  clk,
  input logic                  rst,
  mux2_packet_arbiter_if.slave bus
);

  arb_state_e   state;
  logic         own;
  logic         prio;
  logic         grant;
  logic         g;
  logic         s;
  logic         can_load;
  logic         xfer;
  logic [W-1:0] mux_out;

  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         out_src;

  // While locked only the owner may win, even if it has gone quiet mid-packet.
  always_comb begin
    grant = 1'b0;
    g     = prio;
    if (state == ARB_LOCKED) begin
      g     = own;
      grant = bus.i_valid[own];
    end else if (bus.i_valid[prio]) begin
      g     = prio;
      grant = 1'b1;
    end else if (bus.i_valid[~prio]) begin
      g     = ~prio;
      grant = 1'b1;
    end
  end

  assign s        = g;
  assign can_load = !out_valid || bus.o_ready;
  assign xfer     = !rst && can_load && grant;

  assign bus.i_ready[0] = xfer && !g;
  assign bus.i_ready[1] = xfer && g;

  mux #(
    .N (2),
    .W (W)
  ) mux_inst (
    .din  (bus.i_data),
    .sel  (s),
    .dout (mux_out)
  );

  // Arbitration state only moves on an accepted flit; downstream draining never touches it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      own       <= 1'b0;
      prio      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= mux_out;
      out_last  <= bus.i_last[s];
      out_src   <= g;
      if (bus.i_last[s]) begin
        state <= ARB_IDLE;
        prio  <= ~g;
      end else if (state == ARB_IDLE) begin
        state <= ARB_LOCKED;
        own   <= g;
      end
    end else if (bus.o_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.o_valid = out_valid;
  assign bus.o_data  = out_data;
  assign bus.o_last  = out_last;
  assign bus.o_src   = out_src;

endmodule

// File: tb/tb_mux2_packet_arbiter.sv
// Self-checking bench for mux2_packet_arbiter: directed vector table, hand sequences,
// and randomized traffic against a packet-level reference model.
module tb_mux2_packet_arbiter;

  localparam int W = 16;

  typedef struct {
    logic [1:0]   v;
    logic [1:0]   l;
    logic         r;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic [1:0]   eIrdy;
    logic         eOv;
    logic         eOsrc;
    logic [W-1:0] eOdata;
    logic         eOlast;
  } vec_t;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
    logic         s;
  } flit_t;

  logic clk;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;

  mux2_packet_arbiter_if #(.W(W)) bus ();

  mux2_packet_arbiter #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not terminate");
  end

  function automatic vec_t mk(input logic [1:0] v, input logic [1:0] l, input logic r,
                              input logic [W-1:0] d0, input logic [W-1:0] d1,
                              input logic [1:0] eIrdy, input logic eOv, input logic eOsrc,
                              input logic [W-1:0] eOdata, input logic eOlast);
    vec_t x;
    x.v = v; x.l = l; x.r = r; x.d0 = d0; x.d1 = d1;
    x.eIrdy = eIrdy; x.eOv = eOv; x.eOsrc = eOsrc; x.eOdata = eOdata; x.eOlast = eOlast;
    return x;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change just after the falling edge; checks follow 1 time unit later.
  task automatic applyStimulus(input logic rstIn, input logic [1:0] v, input logic [1:0] l,
                               input logic r, input logic [W-1:0] d0, input logic [W-1:0] d1);
    @(negedge clk);
    rst            = rstIn;
    bus.i_valid    = v;
    bus.i_last     = l;
    bus.o_ready    = r;
    bus.i_data[0]  = d0;
    bus.i_data[1]  = d1;
    #1;
  endtask

  // A requester left waiting must keep its flit unchanged until accepted.
  logic [1:0]   pV, pR, pL;
  logic [W-1:0] pD [2];
  logic         pRst;
  bit           havePrev = 1'b0;

  always @(negedge clk) begin
    #2;
    if (havePrev && !pRst && !rst) begin
      for (int k = 0; k < 2; k++) begin
        if (pV[k] && !pR[k])
          checkOutput($sformatf("hold_req%0d", k),
                      32'({bus.i_valid[k], bus.i_last[k], bus.i_data[k]}),
                      32'({1'b1, pL[k], pD[k]}));
      end
    end
    pV       = bus.i_valid;
    pR       = bus.i_ready;
    pL       = bus.i_last;
    pD[0]    = bus.i_data[0];
    pD[1]    = bus.i_data[1];
    pRst     = rst;
    havePrev = 1'b1;
  end

  logic [1:0]   curV, curL;
  logic [W-1:0] curD [2];
  int           seq [2];
  int           beat [2];
  int           len [2];
  int           nextOut [2];
  int           pktDone [2];
  int           owner, turn, openSrc;
  flit_t        outQ [$];

  initial begin
    vec_t       vecs [29];
    flit_t      f;
    int         w;
    logic [1:0] expRdy;
    logic       ordy;

    rst           = 1'b1;
    bus.i_valid   = 2'b00;
    bus.i_last    = 2'b00;
    bus.o_ready   = 1'b1;
    bus.i_data[0] = '0;
    bus.i_data[1] = '0;

    // Alternation of single-beat packets, then a 3-flit packet from 1 blocking 0.
    vecs[0]  = mk(2'b11, 2'b11, 1'b1, 16'h0A00, 16'h1B00, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b0);
    vecs[1]  = mk(2'b11, 2'b11, 1'b1, 16'h0A01, 16'h1B00, 2'b10, 1'b1, 1'b0, 16'h0A00, 1'b1);
    vecs[2]  = mk(2'b11, 2'b11, 1'b1, 16'h0A01, 16'h1B01, 2'b01, 1'b1, 1'b1, 16'h1B00, 1'b1);
    vecs[3]  = mk(2'b11, 2'b11, 1'b1, 16'h0A02, 16'h1B01, 2'b10, 1'b1, 1'b0, 16'h0A01, 1'b1);
    vecs[4]  = mk(2'b11, 2'b11, 1'b1, 16'h0A02, 16'h1B02, 2'b01, 1'b1, 1'b1, 16'h1B01, 1'b1);
    vecs[5]  = mk(2'b11, 2'b11, 1'b1, 16'h0A03, 16'h1B02, 2'b10, 1'b1, 1'b0, 16'h0A02, 1'b1);
    vecs[6]  = mk(2'b01, 2'b01, 1'b1, 16'h0A03, 16'h0000, 2'b01, 1'b1, 1'b1, 16'h1B02, 1'b1);
    vecs[7]  = mk(2'b00, 2'b00, 1'b1, 16'h0000, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0A03, 1'b1);
    vecs[8]  = mk(2'b00, 2'b00, 1'b1, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0);
    vecs[9]  = mk(2'b10, 2'b00, 1'b1, 16'h0000, 16'h1A0A, 2'b10, 1'b0, 1'b0, 16'h0000, 1'b0);
    vecs[10] = mk(2'b11, 2'b01, 1'b1, 16'h0D0D, 16'h1B0B, 2'b10, 1'b1, 1'b1, 16'h1A0A, 1'b0);
    vecs[11] = mk(2'b11, 2'b11, 1'b1, 16'h0D0D, 16'h1C0C, 2'b10, 1'b1, 1'b1, 16'h1B0B, 1'b0);
    vecs[12] = mk(2'b01, 2'b01, 1'b1, 16'h0D0D, 16'h0000, 2'b01, 1'b1, 1'b1, 16'h1C0C, 1'b1);
    vecs[13] = mk(2'b00, 2'b00, 1'b1, 16'h0000, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0D0D, 1'b1);
    vecs[14] = mk(2'b00, 2'b00, 1'b1, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0);
    // Owner 0 goes quiet mid-packet: requester 1 must not sneak in.
    vecs[15] = mk(2'b01, 2'b00, 1'b1, 16'h0E01, 16'h0000, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b0);
    vecs[16] = mk(2'b10, 2'b10, 1'b1, 16'h0000, 16'h1F01, 2'b00, 1'b1, 1'b0, 16'h0E01, 1'b0);
    vecs[17] = mk(2'b10, 2'b10, 1'b1, 16'h0000, 16'h1F01, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0);
    vecs[18] = mk(2'b11, 2'b11, 1'b1, 16'h0E02, 16'h1F01, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b0);
    vecs[19] = mk(2'b10, 2'b10, 1'b1, 16'h0000, 16'h1F01, 2'b10, 1'b1, 1'b0, 16'h0E02, 1'b1);
    vecs[20] = mk(2'b00, 2'b00, 1'b1, 16'h0000, 16'h0000, 2'b00, 1'b1, 1'b1, 16'h1F01, 1'b1);
    // Downstream stall for three cycles, then no-bubble reload.
    vecs[21] = mk(2'b01, 2'b01, 1'b0, 16'h0C01, 16'h0000, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b0);
    vecs[22] = mk(2'b11, 2'b11, 1'b0, 16'h0C02, 16'h1C02, 2'b00, 1'b1, 1'b0, 16'h0C01, 1'b1);
    vecs[23] = mk(2'b11, 2'b11, 1'b0, 16'h0C02, 16'h1C02, 2'b00, 1'b1, 1'b0, 16'h0C01, 1'b1);
    vecs[24] = mk(2'b11, 2'b11, 1'b0, 16'h0C02, 16'h1C02, 2'b00, 1'b1, 1'b0, 16'h0C01, 1'b1);
    vecs[25] = mk(2'b11, 2'b11, 1'b1, 16'h0C02, 16'h1C02, 2'b10, 1'b1, 1'b0, 16'h0C01, 1'b1);
    vecs[26] = mk(2'b01, 2'b01, 1'b1, 16'h0C02, 16'h0000, 2'b01, 1'b1, 1'b1, 16'h1C02, 1'b1);
    vecs[27] = mk(2'b00, 2'b00, 1'b1, 16'h0000, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0C02, 1'b1);
    vecs[28] = mk(2'b00, 2'b00, 1'b1, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0);

    $display("[TB] reset state");
    applyStimulus(1'b1, 2'b11, 2'b11, 1'b1, 16'h0A00, 16'h1B00);
    applyStimulus(1'b1, 2'b11, 2'b11, 1'b1, 16'h0A00, 16'h1B00);
    checkOutput("reset_i_ready", 32'(bus.i_ready), 32'(2'b00));
    checkOutput("reset_o_valid", 32'(bus.o_valid), 32'(1'b0));
    checkOutput("reset_o_data",  32'(bus.o_data),  32'(16'h0000));
    checkOutput("reset_o_last",  32'(bus.o_last),  32'(1'b0));
    checkOutput("reset_o_src",   32'(bus.o_src),   32'(1'b0));

    $display("[TB] directed vector table");
    for (int i = 0; i < 29; i++) begin
      applyStimulus(1'b0, vecs[i].v, vecs[i].l, vecs[i].r, vecs[i].d0, vecs[i].d1);
      checkOutput($sformatf("vec%0d_i_ready", i), 32'(bus.i_ready), 32'(vecs[i].eIrdy));
      checkOutput($sformatf("vec%0d_o_valid", i), 32'(bus.o_valid), 32'(vecs[i].eOv));
      if (vecs[i].eOv) begin
        checkOutput($sformatf("vec%0d_o_src", i),  32'(bus.o_src),  32'(vecs[i].eOsrc));
        checkOutput($sformatf("vec%0d_o_data", i), 32'(bus.o_data), 32'(vecs[i].eOdata));
        checkOutput($sformatf("vec%0d_o_last", i), 32'(bus.o_last), 32'(vecs[i].eOlast));
      end
    end

    $display("[TB] reset in the middle of a packet");
    applyStimulus(1'b0, 2'b10, 2'b00, 1'b1, 16'h0000, 16'h2A01);
    checkOutput("mid_rst_lock_ready", 32'(bus.i_ready), 32'(2'b10));
    applyStimulus(1'b1, 2'b11, 2'b11, 1'b1, 16'h2B01, 16'h2A02);
    checkOutput("mid_rst_ready_low", 32'(bus.i_ready), 32'(2'b00));
    checkOutput("mid_rst_ovalid_pre", 32'(bus.o_valid), 32'(1'b1));
    checkOutput("mid_rst_odata_pre", 32'(bus.o_data), 32'(16'h2A01));
    applyStimulus(1'b0, 2'b11, 2'b11, 1'b1, 16'h2B01, 16'h2A02);
    checkOutput("post_rst_o_valid", 32'(bus.o_valid), 32'(1'b0));
    checkOutput("post_rst_o_data", 32'(bus.o_data), 32'(16'h0000));
    checkOutput("post_rst_req0_wins", 32'(bus.i_ready), 32'(2'b01));
    applyStimulus(1'b0, 2'b10, 2'b10, 1'b1, 16'h0000, 16'h2A02);
    checkOutput("post_rst_src0", 32'(bus.o_src), 32'(1'b0));
    checkOutput("post_rst_data0", 32'(bus.o_data), 32'(16'h2B01));
    checkOutput("post_rst_req1_next", 32'(bus.i_ready), 32'(2'b10));
    applyStimulus(1'b0, 2'b00, 2'b00, 1'b1, 16'h0000, 16'h0000);
    checkOutput("post_rst_src1", 32'(bus.o_src), 32'(1'b1));
    checkOutput("post_rst_data1", 32'(bus.o_data), 32'(16'h2A02));

    $display("[TB] random traffic against reference model");
    applyStimulus(1'b1, 2'b00, 2'b00, 1'b1, 16'h0000, 16'h0000);
    curV = 2'b00;
    curL = 2'b00;
    for (int k = 0; k < 2; k++) begin
      curD[k]    = '0;
      seq[k]     = 0;
      beat[k]    = 0;
      len[k]     = 1 + int'($urandom_range(3));
      nextOut[k] = 0;
      pktDone[k] = 0;
    end
    owner   = -1;
    turn    = 0;
    openSrc = -1;
    outQ.delete();

    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        if (!curV[k] && $urandom_range(9) < 7) begin
          curV[k] = 1'b1;
          curD[k] = {k[0], seq[k][14:0]};
          curL[k] = (beat[k] == len[k] - 1);
        end
      end
      ordy = ($urandom_range(9) < 7);
      applyStimulus(1'b0, curV, curL, ordy, curD[0], curD[1]);

      // Packet owner keeps the link; otherwise whoever did not win last goes first.
      w = -1;
      if (owner >= 0) begin
        if (curV[owner]) w = owner;
      end else if (curV[turn]) begin
        w = turn;
      end else if (curV[1-turn]) begin
        w = 1 - turn;
      end
      expRdy = 2'b00;
      if (w >= 0 && (outQ.size() == 0 || ordy)) expRdy[w] = 1'b1;
      else w = -1;

      checkOutput("rnd_i_ready", 32'(bus.i_ready), 32'(expRdy));
      checkOutput("rnd_o_valid", 32'(bus.o_valid), 32'(outQ.size() != 0));
      if (outQ.size() != 0) begin
        checkOutput("rnd_o_data", 32'(bus.o_data), 32'(outQ[0].d));
        checkOutput("rnd_o_last", 32'(bus.o_last), 32'(outQ[0].l));
        checkOutput("rnd_o_src",  32'(bus.o_src),  32'(outQ[0].s));
      end

      if (bus.o_valid && ordy) begin
        checkOutput("rnd_beat_origin", 32'(bus.o_data[15]), 32'(bus.o_src));
        checkOutput("rnd_beat_seq", 32'(bus.o_data[14:0]), 32'(nextOut[bus.o_src][14:0]));
        nextOut[bus.o_src]++;
        if (openSrc >= 0) checkOutput("rnd_no_interleave", 32'(bus.o_src), 32'(openSrc));
        if (bus.o_last) begin
          pktDone[bus.o_src]++;
          openSrc = -1;
        end else begin
          openSrc = int'(bus.o_src);
        end
      end

      if (outQ.size() != 0 && ordy) void'(outQ.pop_front());
      if (w >= 0) begin
        f.d = curD[w];
        f.l = curL[w];
        f.s = w[0];
        outQ.push_back(f);
        if (curL[w]) begin
          owner = -1;
          turn  = 1 - w;
        end else begin
          owner = w;
        end
      end

      for (int k = 0; k < 2; k++) begin
        if (curV[k] && bus.i_ready[k]) begin
          seq[k]++;
          if (curL[k]) begin
            beat[k] = 0;
            len[k]  = 1 + int'($urandom_range(3));
          end else begin
            beat[k]++;
          end
          curV[k] = 1'b0;
        end
      end
    end

    checkOutput("fair_pkts_src0", 32'(pktDone[0] > 300), 32'(1'b1));
    checkOutput("fair_pkts_src1", 32'(pktDone[1] > 300), 32'(1'b1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
